// File: rtl/peak_n_finder_pkg.sv
// Shared types for the peak finder: FSM states and the sorted-list entry.
// Entry field widths follow the global VALUE_WIDTH / INDEX_WIDTH macros.
`ifndef VALUE_WIDTH
`define VALUE_WIDTH 16
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 8
`endif

package peak_n_finder_pkg;

  localparam int unsigned NUM_PEAKS_MAX = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  typedef struct packed {
    logic                    occupied;
    logic [`VALUE_WIDTH-1:0] value;
    logic [`INDEX_WIDTH-1:0] index;
  } peak_entry_t;

endpackage

// File: rtl/peak_insert_sorted.sv
// Combinational insert of one candidate into a descending list; the last entry falls off.
// Ties keep the existing entry ahead of the newcomer.
module peak_insert_sorted
  import peak_n_finder_pkg::*;
#(
  parameter int unsigned NUM_PEAKS = 4
) (
  input  logic                        en_i,
  input  peak_entry_t                 cand_i,
  input  peak_entry_t [NUM_PEAKS-1:0] list_i,
  output peak_entry_t [NUM_PEAKS-1:0] list_o
);

  logic [NUM_PEAKS-1:0] take;

  // List is sorted with occupied entries first, so take[] is a thermometer code.
  always_comb begin
    take = '0;
    for (int i = 0; i < NUM_PEAKS; i++) begin
      take[i] = en_i && (!list_i[i].occupied || (cand_i.value > list_i[i].value));
    end
  end

  always_comb begin
    list_o = list_i;
    if (take[0]) begin
      list_o[0] = cand_i;
    end
    for (int i = 1; i < NUM_PEAKS; i++) begin
      if (take[i]) begin
        list_o[i] = take[i-1] ? list_i[i-1] : cand_i;
      end
    end
  end

endmodule

// File: rtl/peak_n_finder.sv
// Streaming top-N peak finder: tracks the NUM_PEAKS largest samples (or local maxima) of a frame
// and publishes them, sorted descending, three edges after the final beat.
`ifndef VALUE_WIDTH
`define VALUE_WIDTH 16
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 8
`endif

module peak_n_finder
  import peak_n_finder_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = `VALUE_WIDTH,
  parameter int unsigned INDEX_WIDTH = `INDEX_WIDTH,
  parameter int unsigned NUM_PEAKS   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid,
  output logic                             ready,
  input  logic                             last,
  input  logic [VALUE_WIDTH-1:0]           input_i,
  input  logic [INDEX_WIDTH-1:0]           index_i,
  input  logic                             mode,
  input  logic [VALUE_WIDTH-1:0]           threshold,
  output logic                             last_out,
  output logic [NUM_PEAKS*VALUE_WIDTH-1:0] peak_final,
  output logic [NUM_PEAKS*INDEX_WIDTH-1:0] index_final,
  output logic [NUM_PEAKS-1:0]             peak_valid,
  output logic [3:0]                       peak_count
);

  state_e                      state_q, state_d;
  peak_entry_t [NUM_PEAKS-1:0] list_q, list_d, base;
  peak_entry_t [NUM_PEAKS-1:0] stage_q, stage_d, out_q, out_d;
  logic                        mode_q, mode_d;
  logic [VALUE_WIDTH-1:0]      thr_q, thr_d, prev_q, prev_d, cur_q, cur_d;
  logic [INDEX_WIDTH-1:0]      cur_idx_q, cur_idx_d;
  logic                        stage_vld_q, stage_vld_d, last_out_q, last_out_d;
  logic                        accept, mode_eff, cand_en;
  logic [VALUE_WIDTH-1:0]      thr_eff;
  peak_entry_t                 cand;

  assign ready    = (state_q == StIdle) || (state_q == StRun);
  assign accept   = valid && ready;
  assign mode_eff = (state_q == StIdle) ? mode : mode_q;
  assign thr_eff  = (state_q == StIdle) ? threshold : thr_q;
  assign last_out = last_out_q;

  // Mode 1 judges the held sample once its successor (or the flush cycle) arrives.
  always_comb begin
    cand    = '0;
    cand_en = 1'b0;
    if (accept && !mode_eff) begin
      cand    = '{occupied: 1'b1, value: input_i, index: index_i};
      cand_en = (input_i >= thr_eff);
    end else if (accept && (state_q == StRun)) begin
      cand    = '{occupied: 1'b1, value: cur_q, index: cur_idx_q};
      cand_en = (cur_q > prev_q) && (cur_q >= input_i) && (cur_q >= thr_q);
    end else if ((state_q == StFlush) && mode_q) begin
      cand    = '{occupied: 1'b1, value: cur_q, index: cur_idx_q};
      cand_en = (cur_q > prev_q) && (cur_q >= thr_q);
    end
  end

  always_comb begin
    base = list_q;
    if (state_q == StIdle) begin
      base = '0;
    end
  end

  peak_insert_sorted #(
    .NUM_PEAKS(NUM_PEAKS)
  ) u_insert (
    .en_i  (cand_en),
    .cand_i(cand),
    .list_i(base),
    .list_o(list_d)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    cur_idx_d   = cur_idx_q;
    stage_d     = stage_q;
    stage_vld_d = 1'b0;
    last_out_d  = stage_vld_q;
    out_d       = stage_vld_q ? stage_q : out_q;
    if (accept) begin
      prev_d    = (state_q == StIdle) ? '0 : cur_q;
      cur_d     = input_i;
      cur_idx_d = index_i;
    end
    case (state_q)
      StIdle: begin
        if (accept) begin
          mode_d  = mode;
          thr_d   = threshold;
          state_d = last ? StFlush : StRun;
        end
      end
      StRun: begin
        if (accept && last) begin
          state_d = StFlush;
        end
      end
      StFlush: state_d = StDone;
      StDone: begin
        // Snapshot here so a frame starting next cycle cannot disturb the published result.
        state_d     = StIdle;
        stage_d     = list_q;
        stage_vld_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      list_q      <= '0;
      stage_q     <= '0;
      out_q       <= '0;
      mode_q      <= 1'b0;
      thr_q       <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      cur_idx_q   <= '0;
      stage_vld_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      list_q      <= list_d;
      stage_q     <= stage_d;
      out_q       <= out_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      cur_idx_q   <= cur_idx_d;
      stage_vld_q <= stage_vld_d;
      last_out_q  <= last_out_d;
    end
  end

  always_comb begin
    peak_final  = '0;
    index_final = '0;
    peak_valid  = '0;
    peak_count  = '0;
    for (int i = 0; i < NUM_PEAKS; i++) begin
      peak_final[i*VALUE_WIDTH +: VALUE_WIDTH]  = out_q[i].value;
      index_final[i*INDEX_WIDTH +: INDEX_WIDTH] = out_q[i].index;
      peak_valid[i]                             = out_q[i].occupied;
      peak_count = peak_count + {3'b000, out_q[i].occupied};
    end
  end

endmodule

// File: tb/tb_peak_n_finder.sv
// Bench for peak_n_finder: fixed vectors, hand-written reset/abort sequences and random frames
// checked against a sort-based reference model.
module tb_peak_n_finder;

  localparam int VW = 16;
  localparam int IW = 8;
  localparam int NP = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              valid = 1'b0;
  logic              ready;
  logic              last = 1'b0;
  logic [VW-1:0]     input_i = '0;
  logic [IW-1:0]     index_i = '0;
  logic              mode = 1'b0;
  logic [VW-1:0]     threshold = '0;
  logic              last_out;
  logic [NP*VW-1:0]  peak_final;
  logic [NP*IW-1:0]  index_final;
  logic [NP-1:0]     peak_valid;
  logic [3:0]        peak_count;

  peak_n_finder #(
    .VALUE_WIDTH(VW),
    .INDEX_WIDTH(IW),
    .NUM_PEAKS  (NP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .ready      (ready),
    .last       (last),
    .input_i    (input_i),
    .index_i    (index_i),
    .mode       (mode),
    .threshold  (threshold),
    .last_out   (last_out),
    .peak_final (peak_final),
    .index_final(index_final),
    .peak_valid (peak_valid),
    .peak_count (peak_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int lo_cnt = 0;

  always @(posedge clk) if (last_out === 1'b1) lo_cnt = lo_cnt + 1;

  typedef struct {
    bit          md;
    int          thr;
    string       seq;
    int          base;
    logic [63:0] pk;
    logic [31:0] ix;
    logic [3:0]  pv;
    int          cnt;
  } vec_t;

  vec_t        vecs[$];
  logic [VW-1:0] fv[$];
  logic [IW-1:0] fi[$];

  logic [63:0] exp_pk;
  logic [31:0] exp_ix;
  logic [3:0]  exp_pv;
  int          exp_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit md, input int thr, input string seq, input int base,
                         input logic [63:0] pk, input logic [31:0] ix, input logic [3:0] pv,
                         input int cnt);
    vec_t v;
    v.md = md; v.thr = thr; v.seq = seq; v.base = base;
    v.pk = pk; v.ix = ix; v.pv = pv; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Reference: collect candidates by the frame rules, then a stable descending top-N selection.
  task automatic model(input bit md, input logic [VW-1:0] thr);
    logic [VW-1:0] cv[$];
    logic [IW-1:0] ci[$];
    bit            used[256];
    int            n;
    n = fv.size();
    for (int k = 0; k < n; k++) begin
      logic [VW-1:0] p, nx;
      bit is_c;
      p  = (k == 0) ? '0 : fv[k-1];
      nx = (k == n - 1) ? '0 : fv[k+1];
      is_c = md ? ((fv[k] > p) && (fv[k] >= nx)) : 1'b1;
      if (is_c && (fv[k] >= thr)) begin
        cv.push_back(fv[k]);
        ci.push_back(fi[k]);
      end
    end
    foreach (used[j]) used[j] = 1'b0;
    exp_pk = '0; exp_ix = '0; exp_pv = '0; exp_cnt = 0;
    for (int s = 0; s < NP; s++) begin
      int best;
      best = -1;
      for (int j = 0; j < cv.size(); j++) begin
        if (!used[j] && (best < 0 || cv[j] > cv[best])) best = j;
      end
      if (best >= 0) begin
        used[best] = 1'b1;
        exp_pk[s*VW +: VW] = cv[best];
        exp_ix[s*IW +: IW] = ci[best];
        exp_pv[s] = 1'b1;
        exp_cnt++;
      end
    end
  endtask

  task automatic cmp_out(input string name, input logic [63:0] pk, input logic [31:0] ix,
                         input logic [3:0] pv, input int cnt);
    logic [63:0] apk;
    logic [31:0] aix;
    apk = peak_final;
    aix = index_final;
    for (int s = 0; s < NP; s++) begin
      if (!pv[s]) begin
        apk[s*VW +: VW] = '0;
        aix[s*IW +: IW] = '0;
      end
    end
    chk({name, " peaks"}, apk, pk);
    chk({name, " indices"}, {32'd0, aix}, {32'd0, ix});
    chk({name, " peak_valid"}, {60'd0, peak_valid}, {60'd0, pv});
    chk({name, " peak_count"}, {60'd0, peak_count}, 64'(cnt));
  endtask

  // Sends fv/fi as one frame starting at a negedge in IDLE; ends 6 edges after the last beat.
  task automatic run_frame(input bit md, input logic [VW-1:0] thr, input int gap,
                           input string name);
    int       first;
    int       lo0;
    logic [2:0] rdy;
    bit       lo4;
    lo0 = lo_cnt;
    for (int k = 0; k < fv.size(); k++) begin
      if (gap > 0 && (k % gap) == gap - 1) begin
        valid = 1'b0;
        input_i = 16'hFFFF;
        @(negedge clk);
      end
      valid     = 1'b1;
      input_i   = fv[k];
      index_i   = fi[k];
      last      = (k == fv.size() - 1);
      mode      = (k == 0) ? md : ~md;
      threshold = (k == 0) ? thr : VW'($urandom_range(0, 20));
      if (ready !== 1'b1) chk({name, " ready at beat"}, {63'd0, ready}, 64'd1);
      @(negedge clk);
    end
    // Push junk while ready is low; none of it may enter the frame.
    valid = 1'b1; last = 1'b1; input_i = 16'hFFFF; index_i = 8'hEE;
    first = -1; rdy = '0; lo4 = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) @(negedge clk);
      if (n <= 2) rdy[n] = ready;
      if (n == 2) begin
        valid = 1'b0;
        last  = 1'b0;
      end
      if (last_out === 1'b1 && first < 0) first = n;
      if (n == 4) lo4 = last_out;
    end
    chk({name, " ready after last"}, {61'd0, rdy}, 64'b100);
    chk({name, " last_out latency"}, 64'(first), 64'd3);
    chk({name, " last_out width"}, {63'd0, lo4}, 64'd0);
    chk({name, " last_out count"}, 64'(lo_cnt - lo0), 64'd1);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset ready", {63'd0, ready}, 64'd1);
    chk("reset last_out", {63'd0, last_out}, 64'd0);
    chk("reset peak_final", peak_final, 64'd0);
    chk("reset index_final", {32'd0, index_final}, 64'd0);
    chk("reset peak_valid", {60'd0, peak_valid}, 64'd0);
    chk("reset peak_count", {60'd0, peak_count}, 64'd0);

    add_vec(0, 0, "593971", 0, {16'd5, 16'd7, 16'd9, 16'd9}, {8'd0, 8'd4, 8'd3, 8'd1}, 4'b1111, 4);
    add_vec(1, 0, "1426638", 0, {16'd0, 16'd4, 16'd6, 16'd8}, {8'd0, 8'd1, 8'd3, 8'd6}, 4'b0111, 3);
    add_vec(1, 5, "232", 0, 64'd0, 32'd0, 4'b0000, 0);
    add_vec(1, 0, "7", 42, {48'd0, 16'd7}, {24'd0, 8'd42}, 4'b0001, 1);
    add_vec(0, 6, "593971", 10, {16'd0, 16'd7, 16'd9, 16'd9}, {8'd0, 8'd14, 8'd13, 8'd11},
            4'b0111, 3);
    add_vec(1, 0, "555", 20, {48'd0, 16'd5}, {24'd0, 8'd20}, 4'b0001, 1);
    add_vec(0, 0, "33333", 30, {16'd3, 16'd3, 16'd3, 16'd3}, {8'd33, 8'd32, 8'd31, 8'd30},
            4'b1111, 4);
    add_vec(1, 0, "0", 5, 64'd0, 32'd0, 4'b0000, 0);

    foreach (vecs[v]) begin
      string nm;
      fv.delete(); fi.delete();
      for (int k = 0; k < vecs[v].seq.len(); k++) begin
        fv.push_back(VW'(vecs[v].seq[k] - 8'd48));
        fi.push_back(IW'(vecs[v].base + k));
      end
      nm = $sformatf("vec%0d", v);
      run_frame(vecs[v].md, VW'(vecs[v].thr), 0, nm);
      cmp_out(nm, vecs[v].pk, vecs[v].ix, vecs[v].pv, vecs[v].cnt);
    end

    // Results hold across idle cycles.
    repeat (5) @(negedge clk);
    chk("hold peak_count", {60'd0, peak_count}, 64'd0);
    chk("hold peak_valid", {60'd0, peak_valid}, 64'd0);

    // 100-sample ramp, with and without a 1-in-7 valid gap.
    fv.delete(); fi.delete();
    for (int k = 0; k < 100; k++) begin
      fv.push_back(VW'(k));
      fi.push_back(IW'(k));
    end
    model(0, 0);
    run_frame(0, 0, 0, "ramp");
    cmp_out("ramp", exp_pk, exp_ix, exp_pv, exp_cnt);
    run_frame(0, 0, 7, "ramp gaps");
    cmp_out("ramp gaps", exp_pk, exp_ix, exp_pv, exp_cnt);

    // Reset mid-frame aborts the frame; the following frame stands alone.
    begin
      int lo0;
      lo0 = lo_cnt;
      for (int k = 0; k < 3; k++) begin
        valid = 1'b1; input_i = VW'(50 + k); index_i = IW'(k); last = 1'b0;
        mode = 1'b0; threshold = '0;
        @(negedge clk);
      end
      valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort ready", {63'd0, ready}, 64'd1);
      chk("abort peak_count", {60'd0, peak_count}, 64'd0);
      repeat (6) @(negedge clk);
      chk("abort no last_out", 64'(lo_cnt - lo0), 64'd0);
      fv = '{16'd4, 16'd9, 16'd2};
      fi = '{8'd7, 8'd8, 8'd9};
      model(0, 0);
      run_frame(0, 0, 0, "after abort");
      cmp_out("after abort", exp_pk, exp_ix, exp_pv, exp_cnt);

      // Reset during FLUSH.
      lo0 = lo_cnt;
      valid = 1'b1; input_i = 16'd3; index_i = 8'd0; last = 1'b0; mode = 1'b1;
      @(negedge clk);
      input_i = 16'd8; index_i = 8'd1; last = 1'b1;
      @(negedge clk);
      valid = 1'b0; last = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("flush abort no last_out", 64'(lo_cnt - lo0), 64'd0);
      chk("flush abort peak_count", {60'd0, peak_count}, 64'd0);
    end

    // Random frames against the model.
    for (int f = 0; f < 25; f++) begin
      bit            md;
      logic [VW-1:0] thr;
      int            len, base, gap;
      string         nm;
      md   = 1'($urandom_range(0, 1));
      thr  = VW'($urandom_range(0, 8));
      len  = $urandom_range(1, 20);
      base = $urandom_range(0, 200);
      gap  = ($urandom_range(0, 1) == 1) ? 3 : 0;
      fv.delete(); fi.delete();
      for (int k = 0; k < len; k++) begin
        fv.push_back(VW'($urandom_range(0, 15)));
        fi.push_back(IW'(base + k));
      end
      nm = $sformatf("rand%0d", f);
      model(md, thr);
      run_frame(md, thr, gap, nm);
      cmp_out(nm, exp_pk, exp_ix, exp_pv, exp_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
